// File: rtl/fifo_pkg.sv
// Shared constants and width helper for the RAM-backed FIFO controller and its output buffer.
package fifo_pkg;
    localparam int BUF_DEPTH      = 2;
    localparam int RAM_RD_LATENCY = 1;

    function automatic int fifo_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/fifo_out_buf.sv
// Two-entry register FIFO that holds RAM read returns; 0-cycle pop, 1-cycle push-to-valid.
// Upstream never pushes into a full buffer, so push has no ready.
module fifo_out_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CW   = $clog2(BUF_DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count
);
    logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        unique case ({i_push, i_pop})
            2'b10: begin
                if (cnt_q == CW'(0)) head_d = i_push_data;
                else                 tail_d = i_push_data;
                cnt_d = cnt_q + CW'(1);
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - CW'(1);
            end
            2'b11: begin
                // Simultaneous push/pop: the new word lands behind whatever remains.
                if (cnt_q == CW'(1)) begin
                    head_d = i_push_data;
                end else begin
                    head_d = tail_q;
                    tail_d = i_push_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_valid = (cnt_q != CW'(0));
    assign o_data  = head_q;
    assign o_count = cnt_q;
endmodule

// File: rtl/ram_fifo_ctrl.sv
// FWFT FIFO controller over a 1-cycle-latency dual-port RAM; write-to-valid 3 cycles, 1 word/cycle.
// Producer has no backpressure (drops flagged on o_overflow); FIFO_STATS_EN adds high-water/drop counters.
module ram_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 256,
    localparam int AW    = fifo_addr_w(DEPTH),
    localparam int CW    = $clog2(DEPTH + 3)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_dv,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic             o_full,
    output logic             o_overflow,
    output logic             o_ram_wr_dv,
    output logic [AW-1:0]    o_ram_wr_addr,
    output logic [WIDTH-1:0] o_ram_wr_data,
    output logic             o_ram_rd_en,
    output logic [AW-1:0]    o_ram_rd_addr,
    input  logic [WIDTH-1:0] i_ram_rd_data,
    input  logic             i_ram_rd_dv,
`ifdef FIFO_STATS_EN
    output logic [CW-1:0]    o_max_count,
    output logic [15:0]      o_drop_cnt,
`endif
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ready,
    output logic [CW-1:0]    o_count
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   ram_count_q, ram_count_d;
    logic          inflight_q, full_q, overflow_q;
    logic          wr_accept, wr_drop, issue, pop;
    logic [1:0]    buf_count;
    logic [2:0]    occ_after_pop;

    assign pop           = o_valid && i_ready;
    assign wr_accept     = i_wr_dv && (ram_count_q != FULL_CNT);
    assign wr_drop       = i_wr_dv && !wr_accept;
    // Only prefetch when the returning word is guaranteed a slot in the output buffer.
    assign occ_after_pop = 3'(buf_count) + 3'(inflight_q) - 3'(pop);
    assign issue         = (ram_count_q != '0) && (occ_after_pop < 3'(BUF_DEPTH));

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ram_count_d = ram_count_q;
        if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
        if (issue)     rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_accept, issue})
            2'b10:   ram_count_d = ram_count_q + 1'b1;
            2'b01:   ram_count_d = ram_count_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_count_q <= '0;
            inflight_q  <= 1'b0;
            full_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_count_q <= ram_count_d;
            inflight_q  <= issue;
            full_q      <= (ram_count_d == FULL_CNT);
            overflow_q  <= wr_drop;
        end
    end

    fifo_out_buf #(.WIDTH(WIDTH)) u_out_buf (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (inflight_q),
        .i_push_data (i_ram_rd_data),
        .i_pop       (pop),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .o_count     (buf_count)
    );

    assign o_ram_wr_dv   = wr_accept && !i_rst;
    assign o_ram_wr_addr = wr_ptr_q;
    assign o_ram_wr_data = i_wr_data;
    assign o_ram_rd_en   = issue && !i_rst;
    assign o_ram_rd_addr = rd_ptr_q;
    assign o_full        = full_q;
    assign o_overflow    = overflow_q;
    assign o_count       = CW'(ram_count_q) + CW'(inflight_q) + CW'(buf_count);

`ifdef FIFO_STATS_EN
    logic [CW-1:0] max_count_q;
    logic [15:0]   drop_cnt_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            max_count_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (o_count > max_count_q) max_count_q <= o_count;
            if (wr_drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign o_max_count = max_count_q;
    assign o_drop_cnt  = drop_cnt_q;
`endif

`ifndef SYNTHESIS
    logic chk_rd_en_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) chk_rd_en_q <= 1'b0;
        else       chk_rd_en_q <= o_ram_rd_en;
    end

    always @(posedge i_clk) begin
        if (!i_rst && (inflight_q != chk_rd_en_q))
            $error("ram_fifo_ctrl: inflight flag disagrees with previous-cycle read enable");
        if (!i_rst && inflight_q && !i_ram_rd_dv)
            $error("ram_fifo_ctrl: RAM did not return data for an issued read");
    end
`endif
endmodule
